// File: rtl/ram_n.sv
// ram_n -- single-port, word-addressed RAM with a hardware clear sequencer.
//
// Parametrised successor to the fixed 8x16 RAM of the Hack-style datapath.
// After reset (or on a clear request) every word is swept to zero, one word
// per cycle, before the memory accepts writes; reads return 0 while busy.
//
// Parameters:
//   WIDTH   data word width in bits (>= 1)
//   DEPTH   number of words (>= 2, need not be a power of two)
//   ADDR_W  address width, derived from DEPTH (do not override)
//   REG_OUT 0 = combinational read, 1 = registered read (1-cycle latency)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   in       write data
//   load     write enable, sampled at posedge clk
//   address  read/write word address
//   clear    request to zero all locations (honoured only when idle)
//   out      read data (0 while busy or for out-of-range addresses)
//   busy     high while the clear sweep runs; writes are ignored

module ram_n #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int REG_OUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              busy
);

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   // One extra bit so DEPTH itself is representable when it is a power of two.
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              addr_ok;
   logic              wr_en;
   logic [WIDTH-1:0]  rd_data;

   assign addr_ok = ({1'b0, address} < DEPTH_W);
   assign busy    = (state == CLEAR);
   // clear wins over load in the same cycle
   assign wr_en   = (state == IDLE) && load && !clear && addr_ok;

   always_comb begin
      rd_data = '0;
      if (addr_ok) begin
         rd_data = mem[address];
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         CLEAR: begin
            if (cnt == LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (clear) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = CLEAR;
            cnt_nx   = '0;
         end
      endcase
   end

   // ---------------- storage (not reset; zeroed by the sweep) ----------------
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[cnt] <= '0;
      end else if (wr_en) begin
         mem[address] <= in;
      end
   end

   // ---------------- read port ----------------
   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [WIDTH-1:0] out_q;

         // Read-before-write: samples the array value present before this edge.
         // Held at 0 during the sweep so the first idle cycle never shows
         // stale data captured mid-sweep.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_q <= '0;
            end else if (busy) begin
               out_q <= '0;
            end else begin
               out_q <= rd_data;
            end
         end

         // Gate as well: on the edge entering CLEAR, out_q still loads memory.
         assign out = busy ? '0 : out_q;
      end else begin : g_comb_out
         assign out = busy ? '0 : rd_data;
      end
   endgenerate

endmodule
